// File: rtl/step_sequencer.sv
// Time-step sequencer and instruction register paired with the control decoder.
// Steps the decoder through T0..T3, latches the instruction byte on request,
// retires instructions on done, and traps halt opcodes and runaway instructions.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for run; counter held at 0, decoder strobes ignored
//   RUN   | instruction in progress; counter walks T0..MAX_STEP
//   HALT  | halt opcode retired; sticky until resetn
//   FAULT | instruction ran past MAX_STEP; sticky until resetn
module step_sequencer #(
  parameter logic [7:0] HALT_OPCODE = 8'h76,
  parameter logic [1:0] MAX_STEP    = 2'd3,
  parameter int         COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   run,
  input  logic [7:0]             data_in,
  input  logic                   rIR_enable,
  input  logic                   counter_clear,
  input  logic                   done,
  output logic [7:0]             rIR_data,
  output logic [1:0]             counter,
  output logic                   busy,
  output logic                   halted,
  output logic                   fault,
  output logic [COUNT_WIDTH-1:0] instr_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2,
    FAULT = 2'd3
  } stateT;

  localparam logic [COUNT_WIDTH-1:0] countOne = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  stateT                  stateReg, stateNext;
  logic [1:0]             counterReg, counterNext;
  logic [7:0]             irReg, irNext;
  logic [COUNT_WIDTH-1:0] countReg, countNext;
  logic                   busyReg, haltedReg, faultReg;

  // State, step counter, instruction register, retire count and status flags.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stateReg   <= IDLE;
      counterReg <= 2'd0;
      irReg      <= 8'h00;
      countReg   <= '0;
      busyReg    <= 1'b0;
      haltedReg  <= 1'b0;
      faultReg   <= 1'b0;
    end else begin
      stateReg   <= stateNext;
      counterReg <= counterNext;
      irReg      <= irNext;
      countReg   <= countNext;
      busyReg    <= (stateNext == RUN);
      haltedReg  <= (stateNext == HALT);
      faultReg   <= (stateNext == FAULT);
    end
  end

  // Next-state logic: done beats counter_clear beats the runaway check.
  // The halt test uses irReg, i.e. the opcode in effect this cycle, so a
  // load coinciding with done does not affect where the instruction goes.
  always_comb begin
    stateNext   = stateReg;
    counterNext = 2'd0;
    countNext   = countReg;
    irNext      = irReg;
    case (stateReg)
      IDLE: begin
        if (run) stateNext = RUN;
      end
      RUN: begin
        if (rIR_enable) irNext = data_in;
        if (done) begin
          countNext = countReg + countOne;
          stateNext = (irReg == HALT_OPCODE) ? HALT : IDLE;
        end else if (counter_clear) begin
          counterNext = 2'd0;
        end else if (counterReg == MAX_STEP) begin
          stateNext = FAULT;
        end else begin
          counterNext = counterReg + 2'd1;
        end
      end
      HALT:    stateNext = HALT;
      FAULT:   stateNext = FAULT;
      default: stateNext = IDLE;
    endcase
  end

  assign rIR_data    = irReg;
  assign counter     = counterReg;
  assign busy        = busyReg;
  assign halted      = haltedReg;
  assign fault       = faultReg;
  assign instr_count = countReg;

endmodule

// File: tb/tb_step_sequencer.sv
// Directed bench for step_sequencer. The retire counter is built 4 bits wide
// here so the all-ones to zero wrap is reached with a handful of instructions.
module tb_step_sequencer;

  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          run = 1'b0;
  logic [7:0]    data_in = 8'h00;
  logic          rIR_enable = 1'b0;
  logic          counter_clear = 1'b0;
  logic          done = 1'b0;
  logic [7:0]    rIR_data;
  logic [1:0]    counter;
  logic          busy;
  logic          halted;
  logic          fault;
  logic [CW-1:0] instr_count;

  int total = 0;
  int bad = 0;

  step_sequencer #(
    .HALT_OPCODE(8'h76),
    .MAX_STEP   (2'd3),
    .COUNT_WIDTH(CW)
  ) dut (
    .clock        (clock),
    .resetn       (resetn),
    .run          (run),
    .data_in      (data_in),
    .rIR_enable   (rIR_enable),
    .counter_clear(counter_clear),
    .done         (done),
    .rIR_data     (rIR_data),
    .counter      (counter),
    .busy         (busy),
    .halted       (halted),
    .fault        (fault),
    .instr_count  (instr_count)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkAll(input string tag, input logic [1:0] c, input logic b,
                        input logic h, input logic f, input logic [CW-1:0] n);
    chk({tag, ".counter"}, {30'd0, counter}, {30'd0, c});
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, b});
    chk({tag, ".halted"}, {31'd0, halted}, {31'd0, h});
    chk({tag, ".fault"}, {31'd0, fault}, {31'd0, f});
    chk({tag, ".count"}, {{(32-CW){1'b0}}, instr_count}, {{(32-CW){1'b0}}, n});
  endtask

  initial begin
    // reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      run = 1'($urandom); data_in = 8'($urandom); rIR_enable = 1'($urandom);
      counter_clear = 1'($urandom); done = 1'($urandom);
      tick();
    end
    chkAll("rst", 2'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    chk("rst.ir", {24'd0, rIR_data}, 32'h00);
    run = 0; rIR_enable = 0; counter_clear = 0; done = 0; data_in = 8'h00;
    resetn = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chkAll("idle5", 2'd0, 1'b0, 1'b0, 1'b0, 4'd0);

    // normal instruction: load 3E in T0, done in T2
    data_in = 8'h3E; run = 1; tick();
    chkAll("nrm.t0", 2'd0, 1'b1, 1'b0, 1'b0, 4'd0);
    run = 0; rIR_enable = 1; tick();
    rIR_enable = 0;
    chkAll("nrm.t1", 2'd1, 1'b1, 1'b0, 1'b0, 4'd0);
    chk("nrm.ir", {24'd0, rIR_data}, 32'h3E);
    tick();
    chkAll("nrm.t2", 2'd2, 1'b1, 1'b0, 1'b0, 4'd0);
    done = 1; tick(); done = 0;
    chkAll("nrm.ret", 2'd0, 1'b0, 1'b0, 1'b0, 4'd1);

    // counter_clear alone in T2, then clear+done together in T1
    run = 1; tick(); run = 0;
    tick(); tick();
    chk("clr.t2", {30'd0, counter}, 32'd2);
    counter_clear = 1; tick(); counter_clear = 0;
    chkAll("clr.restart", 2'd0, 1'b1, 1'b0, 1'b0, 4'd1);
    tick();
    chk("clr.t1", {30'd0, counter}, 32'd1);
    counter_clear = 1; done = 1; tick(); counter_clear = 0; done = 0;
    chkAll("clrdone", 2'd0, 1'b0, 1'b0, 1'b0, 4'd2);
    tick();
    chk("clrdone.idle", {31'd0, busy}, 32'd0);

    // load of halt opcode coinciding with done: old opcode 3E decides
    run = 1; tick(); run = 0;
    data_in = 8'h76; rIR_enable = 1; done = 1; tick();
    rIR_enable = 0; done = 0;
    chkAll("ldret", 2'd0, 1'b0, 1'b0, 1'b0, 4'd3);
    chk("ldret.ir", {24'd0, rIR_data}, 32'h76);

    // back-to-back minimal instructions with run held high, through wrap
    data_in = 8'h00;
    run = 1;
    for (int i = 4; i <= 16; i++) begin
      tick();
      chk("b2b.start", {31'd0, busy}, 32'd1);
      rIR_enable = 1; tick(); rIR_enable = 0;
      chk("b2b.t1", {30'd0, counter}, 32'd1);
      done = 1; tick(); done = 0;
      chk("b2b.gap", {31'd0, busy}, 32'd0);
      chk("b2b.count", {28'd0, instr_count}, 32'(i % 16));
    end
    run = 0;
    tick();
    chkAll("wrap", 2'd0, 1'b0, 1'b0, 1'b0, 4'd0);

    // halt
    run = 1; tick(); run = 0;
    data_in = 8'h76; rIR_enable = 1; tick(); rIR_enable = 0;
    done = 1; tick(); done = 0;
    chkAll("halt", 2'd0, 1'b0, 1'b1, 1'b0, 4'd1);
    run = 1; done = 1; rIR_enable = 1; data_in = 8'h11; tick(); tick();
    run = 0; done = 0; rIR_enable = 0;
    chkAll("halt.sticky", 2'd0, 1'b0, 1'b1, 1'b0, 4'd1);
    chk("halt.ir", {24'd0, rIR_data}, 32'h76);
    resetn = 0; #1;
    chkAll("halt.rst", 2'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    tick(); resetn = 1; tick();

    // runaway instruction
    run = 1; tick(); run = 0;
    tick(); tick(); tick();
    chkAll("run.t3", 2'd3, 1'b1, 1'b0, 1'b0, 4'd0);
    tick();
    chkAll("fault", 2'd0, 1'b0, 1'b0, 1'b1, 4'd0);
    run = 1; done = 1; tick(); tick(); run = 0; done = 0;
    chkAll("fault.sticky", 2'd0, 1'b0, 1'b0, 1'b1, 4'd0);
    resetn = 0; tick(); resetn = 1; tick();
    chkAll("fault.rst", 2'd0, 1'b0, 1'b0, 1'b0, 4'd0);

    // asynchronous reset in T2
    run = 1; tick(); run = 0;
    tick(); tick();
    chkAll("mid.t2", 2'd2, 1'b1, 1'b0, 1'b0, 4'd0);
    #2 resetn = 0; #1;
    chkAll("mid.rst", 2'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    chk("mid.ir", {24'd0, rIR_data}, 32'h00);
    tick(); resetn = 1; tick();
    chkAll("mid.after", 2'd0, 1'b0, 1'b0, 1'b0, 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/step_sequencer.md
# step_sequencer

Time-step sequencer and instruction register that sits opposite the processor's combinational control decoder. It drives the 2-bit step counter and latched instruction byte that the decoder consumes, and obeys the decoder's returned `rIR_enable`, `counter_clear` and `done` strobes. It also gates instruction start on `run`, detects halt and runaway instructions, and counts retired instructions.

## Interface
- `HALT_OPCODE`, 8'h76: opcode whose completion enters HALT.
- `MAX_STEP`, 2'd3: last legal step; legal range 1..3.
- `COUNT_WIDTH`, 16: width of `instr_count`.
- `clock`  in  1  single clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `run`  in  1  start request, level-sampled in IDLE.
- `data_in`  in  8  instruction byte source.
- `rIR_enable`  in  1  from decoder; load `data_in` into the instruction register.
- `counter_clear`  in  1  from decoder; restart the step count at T0 without retiring.
- `done`  in  1  from decoder; current instruction complete.
- `rIR_data`  out  8  instruction register, to decoder.
- `counter`  out  2  current time step T0..T3, to decoder.
- `busy`  out  1  high while in RUN.
- `halted`  out  1  high in HALT.
- `fault`  out  1  high in FAULT.
- `instr_count`  out  COUNT_WIDTH  retired-instruction count.

## Operation
- States: IDLE, RUN, HALT, FAULT. All outputs are registered.
- Reset (`resetn`=0, asynchronous): IDLE, `counter`=0, `rIR_data`=8'h00, `busy`=0, `halted`=0, `fault`=0, `instr_count`=0. Asserting reset mid-instruction aborts the instruction immediately, with no retirement.
- IDLE: `counter` is held at 0. `rIR_enable`, `done` and `counter_clear` are ignored. When `run`=1 at an edge, go to RUN with `counter`=0.
- RUN: evaluate at each edge in priority order:
  1. `done`=1 retires the instruction. `instr_count` increments, wrapping from all-ones to 0. `counter` goes to 0. Next state is HALT if the `rIR_data` in effect during that cycle equals `HALT_OPCODE`, otherwise IDLE.
  2. Else `counter_clear`=1: `counter` goes to 0 and the state stays RUN (re-fetch). No retirement.
  3. Else if `counter`==`MAX_STEP`: go to FAULT with `counter`=0.
  4. Else `counter` increments by 1.
- The instruction register loads independently of the priority list above. In RUN, `rIR_enable`=1 loads `data_in` into `rIR_data` at the edge, in any step. If the load coincides with `done`, the halt check uses the old value.
- HALT and FAULT are sticky. All inputs are ignored and `counter` stays 0. Only `resetn` exits.
- `run` held high continuously starts the next instruction on the cycle after the return to IDLE. This gives one idle cycle between instructions.

## Timing
- `run` sampled at edge k: `busy`=1 and `counter`=0 from edge k. The decoder sees T0 during cycle k→k+1.
- `rIR_enable` asserted in T0: `rIR_data` is valid from the next edge, which is also when T1 begins.
- `done` in step Tn at edge m: `busy`=0, `counter`=0 and `instr_count`+1 are visible after edge m.
- Minimum instruction is 2 cycles (T0 load, `done` in T1). Maximum is `MAX_STEP`+1 steps.
- Runaway detection: with neither `done` nor `counter_clear` in T3, `fault`=1 after the edge ending T3.
- `halted` rises on the edge that retires the halt opcode.

## Test plan
- Reset values: hold `resetn`=0 with random inputs → every output 0. Release with `run`=0 for 5 cycles → still IDLE, `counter`=0.
- Normal instruction: `data_in`=8'h3E, `run` pulse, `rIR_enable` in T0, `done` in T2 → `rIR_data`=8'h3E from T1, `counter` sequence 0,1,2,0, `busy` high for 3 cycles, `instr_count`=1.
- Back-to-back and wrap: preload `instr_count`=16'hFFFF via 65535 minimal instructions (or force), `run` held high → next retirement gives 16'h0000, with one idle cycle between instructions.
- Clear vs done priority: `counter_clear` alone in T2 → `counter` returns to 0, `busy` stays 1. Then `counter_clear`=1 and `done`=1 together in T1 → retires, IDLE, count increments once.
- Halt: load 8'h76, `done` in T1 → `halted`=1, `busy`=0. Subsequent `run` pulses are ignored. `resetn` pulse clears `halted`.
- Fault and mid-op reset: no `done` or `counter_clear` through T3 → `fault`=1, `counter`=0. Separately, assert `resetn`=0 asynchronously in T2 → all outputs 0 immediately, `instr_count` unchanged from 0.
